// File: rtl/pipeline_stall_ctrl.sv
// pipeline_stall_ctrl: central stall/flush sequencer for the 5-stage pipeline
//   inputs : hz_load_use, br_taken, dmem_busy, halt_req (clk, async active-high rst)
//   outputs: pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_bubble,
//            ex_mem_write, mem_wb_write, halted, stall_cnt, flush_cnt
module pipeline_stall_ctrl #(
  parameter int LOAD_USE_CYCLES = 1,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hz_load_use,
  input  logic             br_taken,
  input  logic             dmem_busy,
  input  logic             halt_req,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             if_id_flush,
  output logic             id_ex_write,
  output logic             id_ex_bubble,
  output logic             ex_mem_write,
  output logic             mem_wb_write,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);
  typedef enum logic [1:0] {RUN, LU_STALL, HALT} state_t;
  localparam bit MULTI = LOAD_USE_CYCLES > 1;
  localparam logic [3:0] LU_INIT = 4'(LOAD_USE_CYCLES - 1);
  state_t state;
  logic [3:0] lu_left;
  logic in_halt, freeze, stall, flush, down;
  always_comb begin
    in_halt = state == HALT;
    freeze = !in_halt && dmem_busy;
    // halt_req only wins when no branch is being flushed in the same cycle
    stall = !freeze && (state == LU_STALL ||
            (state == RUN && (hz_load_use || (!br_taken && halt_req))));
    flush = state == RUN && !dmem_busy && !hz_load_use && br_taken;
    // in HALT the downstream stages keep draining whenever memory is ready
    down = !rst && (in_halt ? !dmem_busy : !freeze);
    pc_write = !rst && !in_halt && !freeze && !stall;
    if_id_write = pc_write;
    if_id_flush = !rst && flush;
    id_ex_write = down;
    ex_mem_write = down;
    mem_wb_write = down;
    id_ex_bubble = rst || in_halt || stall;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= RUN;
      lu_left <= '0;
      halted <= 1'b0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (state == RUN && !dmem_busy) begin
        if (hz_load_use) begin
          if (MULTI) begin
            state <= LU_STALL;
            lu_left <= LU_INIT;
          end
        end else if (!br_taken && halt_req) begin
          state <= HALT;
          halted <= 1'b1;
        end
      end else if (state == LU_STALL && !dmem_busy) begin
        lu_left <= lu_left - 4'd1;
        if (lu_left == 4'd1) state <= RUN;
      end
      if (!pc_write && !in_halt && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
      if (if_id_flush && flush_cnt != '1) flush_cnt <= flush_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// tb_pipeline_stall_ctrl: vector table plus randomized model check of two stall controller configs
module tb_pipeline_stall_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1, hz = 1'b0, br = 1'b0, busy = 1'b0, hlt = 1'b0;
  always #5 clk = ~clk;
  logic a_pc, a_ifw, a_fl, a_idw, a_bub, a_exw, a_wbw, a_h;
  logic b_pc, b_ifw, b_fl, b_idw, b_bub, b_exw, b_wbw, b_h;
  logic [15:0] a_sc, a_fc;
  logic [3:0] b_sc, b_fc;
  pipeline_stall_ctrl #(.LOAD_USE_CYCLES(3), .CNT_W(16)) dut_a (
    .clk(clk), .rst(rst), .hz_load_use(hz), .br_taken(br), .dmem_busy(busy), .halt_req(hlt),
    .pc_write(a_pc), .if_id_write(a_ifw), .if_id_flush(a_fl), .id_ex_write(a_idw),
    .id_ex_bubble(a_bub), .ex_mem_write(a_exw), .mem_wb_write(a_wbw), .halted(a_h),
    .stall_cnt(a_sc), .flush_cnt(a_fc));
  pipeline_stall_ctrl #(.LOAD_USE_CYCLES(1), .CNT_W(4)) dut_b (
    .clk(clk), .rst(rst), .hz_load_use(hz), .br_taken(br), .dmem_busy(busy), .halt_req(hlt),
    .pc_write(b_pc), .if_id_write(b_ifw), .if_id_flush(b_fl), .id_ex_write(b_idw),
    .id_ex_bubble(b_bub), .ex_mem_write(b_exw), .mem_wb_write(b_wbw), .halted(b_h),
    .stall_cnt(b_sc), .flush_cnt(b_fc));
  int ncmp = 0, nfail = 0;
  int lu_len[2] = '{3, 1};
  int cmax[2] = '{65535, 15};
  int owed[2], sc[2], fc[2];
  bit hm[2];
  typedef struct packed {
    logic r, l, b, m, h;
    logic pc, bub, fl, wb;
    logic [15:0] sc, fc;
    logic hd;
  } vec_t;
  vec_t tbl[24];
  task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
    ncmp++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", n, got, exp);
    end
  endtask
  // reference: a load-use owes LOAD_USE_CYCLES non-busy stall cycles; halt is sticky until reset
  task automatic model(input int d, input logic [7:0] got, input logic [15:0] gs, input logic [15:0] gf);
    bit pc, fl, bub, dn;
    pc = 0; fl = 0; bub = 0; dn = 0;
    if (rst) bub = 1;
    else if (hm[d]) begin bub = 1; dn = !busy; end
    else if (busy) ;
    else if (owed[d] > 0 || hz || (hlt && !br)) begin bub = 1; dn = 1; end
    else begin pc = 1; dn = 1; fl = br; end
    chk(d ? "b_ctl" : "a_ctl", {24'd0, got}, {24'd0, pc, pc, fl, dn, bub, dn, dn, rst ? 1'b0 : hm[d]});
    chk(d ? "b_stall_cnt" : "a_stall_cnt", {16'd0, gs}, rst ? 0 : sc[d]);
    chk(d ? "b_flush_cnt" : "a_flush_cnt", {16'd0, gf}, rst ? 0 : fc[d]);
    if (rst) begin
      owed[d] = 0; sc[d] = 0; fc[d] = 0; hm[d] = 0;
    end else begin
      if (!pc && !hm[d] && sc[d] < cmax[d]) sc[d]++;
      if (fl && fc[d] < cmax[d]) fc[d]++;
      if (!hm[d] && !busy) begin
        if (owed[d] > 0) owed[d]--;
        else if (hz) owed[d] = lu_len[d] - 1;
        else if (!br && hlt) hm[d] = 1;
      end
    end
  endtask
  task automatic cycle(input logic r, input logic l, input logic b, input logic m, input logic h);
    @(posedge clk);
    #1;
    rst = r; hz = l; br = b; busy = m; hlt = h;
    #3;
    model(0, {a_pc, a_ifw, a_fl, a_idw, a_bub, a_exw, a_wbw, a_h}, a_sc, a_fc);
    model(1, {b_pc, b_ifw, b_fl, b_idw, b_bub, b_exw, b_wbw, b_h}, {12'd0, b_sc}, {12'd0, b_fc});
  endtask
  initial begin
    tbl = '{
      '{1,0,0,0,0, 0,1,0,0, 16'd0, 16'd0, 0},
      '{0,0,0,0,0, 1,0,0,1, 16'd0, 16'd0, 0},
      '{0,0,0,0,0, 1,0,0,1, 16'd0, 16'd0, 0},
      '{0,0,0,0,0, 1,0,0,1, 16'd0, 16'd0, 0},
      '{0,1,0,0,0, 0,1,0,1, 16'd0, 16'd0, 0},
      '{0,0,0,0,0, 0,1,0,1, 16'd1, 16'd0, 0},
      '{0,0,0,0,0, 0,1,0,1, 16'd2, 16'd0, 0},
      '{0,0,0,0,0, 1,0,0,1, 16'd3, 16'd0, 0},
      '{0,1,0,0,0, 0,1,0,1, 16'd3, 16'd0, 0},
      '{0,0,0,1,0, 0,0,0,0, 16'd4, 16'd0, 0},
      '{0,0,0,1,0, 0,0,0,0, 16'd5, 16'd0, 0},
      '{0,0,0,0,0, 0,1,0,1, 16'd6, 16'd0, 0},
      '{0,0,0,0,0, 0,1,0,1, 16'd7, 16'd0, 0},
      '{0,0,0,0,0, 1,0,0,1, 16'd8, 16'd0, 0},
      '{0,1,1,0,0, 0,1,0,1, 16'd8, 16'd0, 0},
      '{0,0,1,0,0, 0,1,0,1, 16'd9, 16'd0, 0},
      '{0,0,1,0,0, 0,1,0,1, 16'd10, 16'd0, 0},
      '{0,0,1,0,0, 1,0,1,1, 16'd11, 16'd0, 0},
      '{0,0,0,0,0, 1,0,0,1, 16'd11, 16'd1, 0},
      '{0,0,0,0,1, 0,1,0,1, 16'd11, 16'd1, 0},
      '{0,0,0,0,0, 0,1,0,1, 16'd12, 16'd1, 1},
      '{0,0,0,1,0, 0,1,0,0, 16'd12, 16'd1, 1},
      '{0,1,1,0,1, 0,1,0,1, 16'd12, 16'd1, 1},
      '{1,0,0,0,0, 0,1,0,0, 16'd0, 16'd0, 0}
    };
    for (int i = 0; i < 24; i++) begin
      cycle(tbl[i].r, tbl[i].l, tbl[i].b, tbl[i].m, tbl[i].h);
      chk($sformatf("tbl%0d_ctl", i), {27'd0, a_pc, a_bub, a_fl, a_wbw, a_h},
          {27'd0, tbl[i].pc, tbl[i].bub, tbl[i].fl, tbl[i].wb, tbl[i].hd});
      chk($sformatf("tbl%0d_stall_cnt", i), {16'd0, a_sc}, {16'd0, tbl[i].sc});
      chk($sformatf("tbl%0d_flush_cnt", i), {16'd0, a_fc}, {16'd0, tbl[i].fc});
    end
    for (int i = 0; i < 10; i++) cycle(0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 1);
    for (int i = 0; i < 20; i++) begin
      cycle(0, 0, 0, 1'($urandom_range(0, 1)), 0);
      chk("halt_pc_write", {31'd0, a_pc}, 0);
      chk("halt_mem_wb", {31'd0, a_wbw}, {31'd0, !busy});
    end
    cycle(1, 0, 0, 0, 0);
    for (int i = 0; i < 20; i++) cycle(0, 1, 0, 0, 0);
    chk("b_stall_sat", {28'd0, b_sc}, 32'd15);
    for (int i = 0; i < 600; i++)
      cycle($urandom_range(0, 39) == 0, $urandom_range(0, 4) == 0, $urandom_range(0, 3) == 0,
            $urandom_range(0, 3) == 0, $urandom_range(0, 29) == 0);
    $display("End of test - %0d assertions evaluated, %0d failures", ncmp, nfail);
    $finish;
  end
endmodule
